uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmitter. Accepts parallel words, holds one pending word, and sequences one frame per word: start bit, WIDTH data bits LSB first, an optional parity bit and one stop bit. It drives the serializer load/shift, the parity calculator's DATA_VALID and PAR_FLAG, and the TX output mux select. CLK is the TX bit clock, so each frame bit lasts exactly one CLK cycle.

---
 rtl/uart_tx_ctrl_if.sv | 24 ++
 rtl/uart_tx_ctrl.sv | 111 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Word-write side and serializer/parity/mux control side of the UART TX frame sequencer.
interface uart_tx_ctrl_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] p_data;
    logic             data_valid;
    logic             par_en;
    logic [WIDTH-1:0] ser_data;
    logic             ser_load;
    logic             ser_en;
    logic             par_flag;
    logic [1:0]       mux_sel;
    logic             busy;
    logic             full;
    logic             overrun;

    modport master (
        output p_data, data_valid, par_en,
        input  ser_data, ser_load, ser_en, par_flag, mux_sel, busy, full, overrun
    );

    modport slave (
        input  p_data, data_valid, par_en,
        output ser_data, ser_load, ser_en, par_flag, mux_sel, busy, full, overrun
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, WIDTH data bits, optional parity, stop; one-word pending buffer.
module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ser_data, hold;
    logic             full, par_en_r, overrun;
    logic             last_bit;
    logic [1:0]       mux_sel;
    logic             ser_load, ser_en, par_flag;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mux_sel   = 2'b11;
        ser_load  = 1'b0;
        ser_en    = 1'b0;
        par_flag  = 1'b0;
        case (state)
            IDLE:   if (bus.data_valid) state_nxt = START;
            START: begin
                mux_sel   = 2'b00;
                ser_load  = 1'b1;
                state_nxt = DATA;
            end
            DATA: begin
                mux_sel = 2'b01;
                ser_en  = 1'b1;
                if (last_bit) begin
                    par_flag  = par_en_r;
                    state_nxt = par_en_r ? PARITY : STOP;
                end
            end
            PARITY: begin
                mux_sel   = 2'b10;
                state_nxt = STOP;
            end
            STOP:    state_nxt = (full || bus.data_valid) ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ser_data <= '0;
            hold     <= '0;
            cnt      <= '0;
            full     <= 1'b0;
            par_en_r <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.data_valid) begin
                        ser_data <= bus.p_data;
                        par_en_r <= bus.par_en;
                    end
                end
                STOP: begin
                    // Hold drains into the next frame; a same-cycle write refills it without overrun.
                    if (full) begin
                        ser_data <= hold;
                        par_en_r <= bus.par_en;
                        if (bus.data_valid) hold <= bus.p_data;
                        else                full <= 1'b0;
                    end else if (bus.data_valid) begin
                        ser_data <= bus.p_data;
                        par_en_r <= bus.par_en;
                    end
                end
                default: begin
                    if (state == START) cnt <= '0;
                    else if (state == DATA) cnt <= cnt + CW'(1);
                    if (bus.data_valid) begin
                        if (!full) begin
                            hold <= bus.p_data;
                            full <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ser_data = ser_data;
    assign bus.ser_load = ser_load;
    assign bus.ser_en   = ser_en;
    assign bus.par_flag = par_flag;
    assign bus.mux_sel  = mux_sel;
    assign bus.busy     = (state != IDLE);
    assign bus.full     = full;
    assign bus.overrun  = overrun;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame shape, parity, pending buffer, overrun and mid-frame reset.
module tb_uart_tx_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    uart_tx_ctrl_if #(.WIDTH(W)) bus();

    uart_tx_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         inj_pos [2];
    logic [7:0] inj_w   [2];
    int         ovr_pos;
    bit         tog;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic no_inj;
        inj_pos = '{-1, -1};
        ovr_pos = -1;
        tog     = 1'b0;
    endtask

    // Consumes the pending start request, then checks every cycle START..STOP; returns in STOP.
    task automatic frame_chk(input string tag, input logic [7:0] word, input bit par);
        int last;
        last = 9 + int'(par);
        tick;
        for (int p = 0; p <= last; p++) begin
            logic [1:0] m;
            m = (p == 0) ? 2'b00 : (p <= 8) ? 2'b01 : (p == last) ? 2'b11 : 2'b10;
            chk($sformatf("%s.mux%0d", tag, p), 32'(bus.mux_sel), 32'(m));
            if (p == 0) chk($sformatf("%s.word", tag), 32'(bus.ser_data), 32'(word));
            chk($sformatf("%s.load%0d", tag, p), 32'(bus.ser_load), 32'(p == 0));
            chk($sformatf("%s.en%0d", tag, p), 32'(bus.ser_en), 32'(p >= 1 && p <= 8));
            chk($sformatf("%s.pflag%0d", tag, p), 32'(bus.par_flag), 32'(p == 8 && par));
            chk($sformatf("%s.busy%0d", tag, p), 32'(bus.busy), 32'd1);
            chk($sformatf("%s.ovr%0d", tag, p), 32'(bus.overrun), 32'(p == ovr_pos));
            bus.data_valid = 1'b0;
            for (int k = 0; k < 2; k++)
                if (p == inj_pos[k]) begin
                    bus.data_valid = 1'b1;
                    bus.p_data     = inj_w[k];
                end
            if (tog) bus.par_en = ~bus.par_en;
            if (p < last) tick;
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".idle_mux"}, 32'(bus.mux_sel), 32'd3);
        chk({tag, ".idle_load"}, 32'(bus.ser_load), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int loads, busy_n;
        bus.p_data     = '0;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        no_inj();
        rst = 1'b1;
        tick;
        tick;
        chk("rst.mux", 32'(bus.mux_sel), 32'd3);
        chk("rst.ser_data", 32'(bus.ser_data), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.full", 32'(bus.full), 32'd0);
        chk("rst.ovr", 32'(bus.overrun), 32'd0);
        chk("rst.load", 32'(bus.ser_load), 32'd0);
        chk("rst.en", 32'(bus.ser_en), 32'd0);
        chk("rst.pflag", 32'(bus.par_flag), 32'd0);
        rst = 1'b0;
        tick;

        // 1: parity frame, 11 cycles
        bus.p_data = 8'hA5; bus.par_en = 1'b1; bus.data_valid = 1'b1;
        frame_chk("t1", 8'hA5, 1'b1);
        tick;
        idle_chk("t1");

        // 2: no parity, PAR_EN toggled mid-frame
        bus.p_data = 8'h3C; bus.par_en = 1'b0; bus.data_valid = 1'b1;
        tog = 1'b1;
        frame_chk("t2", 8'h3C, 1'b0);
        tick;
        idle_chk("t2");
        no_inj();

        // 3: 0x22 buffered, 0x33 dropped, back-to-back
        bus.p_data = 8'h11; bus.par_en = 1'b0; bus.data_valid = 1'b1;
        inj_pos = '{2, 5}; inj_w = '{8'h22, 8'h33}; ovr_pos = 6;
        frame_chk("t3a", 8'h11, 1'b0);
        chk("t3a.full", 32'(bus.full), 32'd1);
        no_inj();
        frame_chk("t3b", 8'h22, 1'b0);
        chk("t3b.full", 32'(bus.full), 32'd0);
        tick;
        idle_chk("t3");

        // 4: write in STOP while full refills hold with no overrun
        bus.p_data = 8'h55; bus.data_valid = 1'b1;
        inj_pos = '{3, 9}; inj_w = '{8'h66, 8'h44};
        frame_chk("t4a", 8'h55, 1'b0);
        no_inj();
        frame_chk("t4b", 8'h66, 1'b0);
        chk("t4b.full", 32'(bus.full), 32'd1);
        frame_chk("t4c", 8'h44, 1'b0);
        chk("t4c.full", 32'(bus.full), 32'd0);
        tick;
        idle_chk("t4");

        // 5: reset in 4th DATA cycle with a pending word
        bus.p_data = 8'h77; bus.data_valid = 1'b1;
        tick;
        chk("t5.start_load", 32'(bus.ser_load), 32'd1);
        bus.p_data = 8'h88;
        tick;
        bus.data_valid = 1'b0;
        chk("t5.full", 32'(bus.full), 32'd1);
        repeat (3) tick;
        chk("t5.data4_mux", 32'(bus.mux_sel), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5.rst_mux", 32'(bus.mux_sel), 32'd3);
        chk("t5.rst_full", 32'(bus.full), 32'd0);
        chk("t5.rst_busy", 32'(bus.busy), 32'd0);
        loads = 0;
        busy_n = 0;
        repeat (12) begin
            tick;
            loads  += int'(bus.ser_load);
            busy_n += int'(bus.busy);
        end
        chk("t5.no_load", 32'(loads), 32'd0);
        chk("t5.no_busy", 32'(busy_n), 32'd0);
        bus.p_data = 8'h99; bus.data_valid = 1'b1;
        frame_chk("t5b", 8'h99, 1'b0);
        tick;
        idle_chk("t5b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
